// File: rtl/shift_seq.sv
// Counted shift sequencer: rotates {carry,data} one position per clock under valid/ready flow control.
// Define SHIFT_SEQ_ARITH_EN to make op 2 an arithmetic right shift instead of rotate-right-through-carry.
module shift_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic             carryIn,
    input  logic [WIDTH-1:0] dataIn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataOut,
    output logic             carryOut,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } stateT;

    stateT            state, stateNext;
    logic [WIDTH-1:0] data, dataNext;
    logic             carry, carryNext;
    logic [CNT_W-1:0] remaining, remainingNext;
    logic             shiftRight, shiftRightNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            data       <= '0;
            carry      <= 1'b0;
            remaining  <= '0;
            shiftRight <= 1'b0;
        end else begin
            state      <= stateNext;
            data       <= dataNext;
            carry      <= carryNext;
            remaining  <= remainingNext;
            shiftRight <= shiftRightNext;
        end
    end

    always_comb begin
        stateNext      = state;
        dataNext       = data;
        carryNext      = carry;
        remainingNext  = remaining;
        shiftRightNext = shiftRight;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    case (op)
                        2'd0: begin
                            dataNext  = dataIn;
                            carryNext = 1'b0;
                            stateNext = DONE;
                        end
                        2'd3: begin
                            dataNext  = '0;
                            carryNext = 1'b0;
                            stateNext = DONE;
                        end
                        default: begin
                            dataNext       = dataIn;
                            carryNext      = carryIn;
                            remainingNext  = count;
                            shiftRightNext = (op == 2'd2);
                            stateNext      = (count == '0) ? DONE : SHIFT;
                        end
                    endcase
                end
            end
            SHIFT: begin
                if (shiftRight) begin
`ifdef SHIFT_SEQ_ARITH_EN
                    dataNext = {data[WIDTH-1], data[WIDTH-1:1]};
`else
                    dataNext = {carry, data[WIDTH-1:1]};
`endif
                    carryNext = data[0];
                end else begin
                    dataNext  = {data[WIDTH-2:0], carry};
                    carryNext = data[WIDTH-1];
                end
                remainingNext = remaining - CNT_W'(1);
                // The step consumed with one count left is the final one.
                if (remaining == CNT_W'(1)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dataOut   = data;
    assign carryOut  = carry;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed cases plus random requests against a rotation-arithmetic model.
// Honours SHIFT_SEQ_ARITH_EN so the model tracks whichever op 2 flavour is built.
module tb_shift_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       op = '0;
    logic [CNT_W-1:0] count = '0;
    logic             carryIn = 1'b0;
    logic [WIDTH-1:0] dataIn = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] dataOut;
    logic             carryOut;
    logic             busy;

    int compared = 0;
    int mismatched = 0;

    shift_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op),
        .count(count),
        .carryIn(carryIn),
        .dataIn(dataIn),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dataOut(dataOut),
        .carryOut(carryOut),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Treat {carry,data} as a 9-bit value and rotate it by the count in one go.
    function automatic void refModel(input int opv, input int cnt, input int cin, input int din,
                                     output int dout, output int cout);
        int v;
        int k;
        int s;
        dout = 0;
        cout = 0;
        if (opv == 0) begin
            dout = din;
        end else if (opv == 3) begin
            dout = 0;
        end else if (cnt == 0) begin
            dout = din;
            cout = cin;
        end else if (opv == 1) begin
            v = (cin << 8) | din;
            k = cnt % 9;
            v = ((v << k) | (v >> (9 - k))) & 'h1FF;
            dout = v & 'hFF;
            cout = (v >> 8) & 1;
        end else begin
`ifdef SHIFT_SEQ_ARITH_EN
            s = (din >= 128) ? din - 256 : din;
            dout = (s >>> cnt) & 'hFF;
            cout = (din >> (cnt - 1)) & 1;
`else
            s = 0;
            v = (cin << 8) | din;
            k = cnt % 9;
            v = ((v >> k) | (v << (9 - k))) & 'h1FF;
            dout = v & 'hFF;
            cout = (v >> 8) & 1;
`endif
        end
    endfunction

    task automatic applyStimulus(input int opv, input int cnt, input int cin, input int din, input int hold);
        int expData;
        int expCarry;
        int expLat;
        int lat;
        refModel(opv, cnt, cin, din, expData, expCarry);
        expLat = ((opv == 1 || opv == 2) && cnt != 0) ? cnt : 0;
        checkOutput("inReadyIdle", in_ready, 1);
        out_ready = 1'b0;
        op       = opv[1:0];
        count    = cnt[CNT_W-1:0];
        carryIn  = cin[0];
        dataIn   = din[WIDTH-1:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 2'($urandom);
        count    = CNT_W'($urandom);
        carryIn  = 1'($urandom);
        dataIn   = WIDTH'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 20) checkOutput("timeout", out_valid, 1);
        checkOutput("latency", lat, expLat);
        checkOutput("dataOut", dataOut, expData);
        checkOutput("carryOut", carryOut, expCarry);
        checkOutput("busyDone", busy, 1);
        checkOutput("inReadyDone", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("holdValid", out_valid, 1);
            checkOutput("holdData", {carryOut, dataOut}, (expCarry << 8) | expData);
            checkOutput("holdInReady", in_ready, 0);
        end
        // Offer a new request on the release edge; it must not be taken in that same cycle.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = 2'd1;
        count     = 3'd5;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("releaseValid", out_valid, 0);
        checkOutput("releaseBusy", busy, 0);
    endtask

    task automatic checkAbort();
        op       = 2'd1;
        count    = 3'd7;
        carryIn  = 1'b1;
        dataIn   = 8'hA5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abortBusyBefore", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abortValid", out_valid, 0);
        checkOutput("abortData", dataOut, 0);
        checkOutput("abortCarry", carryOut, 0);
        checkOutput("abortBusy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abortInReady", in_ready, 1);
        checkOutput("abortValidAfter", out_valid, 0);
    endtask

    initial begin
        $display("[TB] starting shift_seq bench");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstValid", out_valid, 0);
        checkOutput("rstData", dataOut, 0);
        checkOutput("rstBusy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstInReady", in_ready, 1);
        checkOutput("rstCarry", carryOut, 0);
        checkOutput("rstValidAfter", out_valid, 0);

        applyStimulus(1, 3, 1, 'h81, 1);
        applyStimulus(2, 2, 0, 'h01, 0);
        applyStimulus(2, 2, 0, 'h80, 2);
        applyStimulus(0, 4, 1, 'h5A, 0);
        applyStimulus(3, 6, 1, 'hFF, 0);
        applyStimulus(1, 0, 1, 'h33, 1);
        applyStimulus(2, 0, 1, 'hC4, 0);
        applyStimulus(1, 7, 0, 'h96, 5);
        applyStimulus(2, 7, 1, 'h6B, 5);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 3)));
        end

        checkAbort();
        applyStimulus(1, 1, 0, 'h80, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle shift sequencer for the 8-bit datapath. Shifts an operand by a programmable count, one bit per clock, rotating through a carry flag.
- Upstream is a decode/issue stage, connected by a valid/ready handshake. Downstream is the ALU operand/flag path, also valid/ready, which consumes the result and carry.
- Extends the single-step operand shifter to counted shifts under flow control.

Parameters:
- WIDTH, 8, operand width in bits.
- CNT_W, 3, width of the shift-count field; maximum count is 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream request valid.
- in_ready  out  1  block can accept a request.
- op  in  2  operation: 0 pass, 1 shift left, 2 shift right, 3 clear.
- count  in  CNT_W  number of single-bit steps for ops 1/2.
- carryIn  in  1  initial carry for ops 1/2.
- dataIn  in  WIDTH  operand.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- dataOut  out  WIDTH  result.
- carryOut  out  1  result carry.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, data=0, carry=0, remaining=0.
  - Outputs: out_valid=0, dataOut=0, carryOut=0, busy=0, in_ready=1 after release.
  - Reset mid-operation aborts immediately. No partial result is ever presented.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch the request:
    - op 0: data=dataIn, carry=0 -> DONE.
    - op 3: data=0, carry=0 -> DONE.
    - op 1/2 with count=0: data=dataIn, carry=carryIn -> DONE.
    - op 1/2 with count>0: data=dataIn, carry=carryIn, remaining=count -> SHIFT.
- SHIFT (one step per clock; in_ready=0):
  - Left step: data<={data[W-2:0],carry}, carry<=data[W-1].
  - Right step: data<={carry,data[W-1:1]}, carry<=data[0].
  - Net effect: the (WIDTH+1)-bit {carry,data} rotates by one position per step.
  - remaining decrements each step. The step taken with remaining==1 transitions to DONE.
- DONE:
  - out_valid=1; dataOut/carryOut are held stable; in_ready=0.
  - On out_ready -> IDLE.
  - No same-cycle re-accept: a new request is taken at the earliest on the cycle after returning to IDLE.
- Latency:
  - Accept edge E0.
  - out_valid is high after edge E0+n for count n>0 (ops 1/2).
  - out_valid is high after E0 itself for op 0, op 3, or count 0.
- Input sampling and output visibility:
  - op, count, carryIn and dataIn are sampled only at accept. Changes during SHIFT/DONE are ignored.
  - dataOut/carryOut continuously reflect the internal registers. Only the DONE value is architecturally valid.
- Backpressure: DONE holds indefinitely while out_ready=0.
- Count values are treated as unsigned. Any count up to 2^CNT_W-1 is legal, including counts >= WIDTH; the rotation simply continues.

Optional Feature:
- Macro: SHIFT_SEQ_ARITH_EN.
- When defined, op 2 becomes an arithmetic right shift:
  - Each step: data<={data[W-1],data[W-1:1]}, carry<=data[0].
  - carryIn is used only as the result carry when count=0.
- When undefined, op 2 is rotate-right-through-carry as described above.
- ops 0, 1 and 3 are identical in both builds.

Test Plan:
- Reset: rst_n low, then high -> out_valid=0, dataOut=0x00, carryOut=0, in_ready=1, busy=0.
- Rotate left: op=1, dataIn=0x81, carryIn=1, count=3 -> out_valid after E0+3; dataOut=0x0E, carryOut=0. Intermediate states are 0x03/c1, then 0x07/c0.
- Rotate right: op=2, dataIn=0x01, carryIn=0, count=2 -> dataOut=0x80, carryOut=0.
- Arithmetic right: op=2, dataIn=0x80, count=2.
  - With SHIFT_SEQ_ARITH_EN -> 0xE0, c0.
  - Without it (carryIn=0) -> 0x20, c0.
- Pass, clear and zero count: all three reach DONE one edge after accept.
  - op=0, dataIn=0x5A -> 0x5A, c0.
  - op=3 -> 0x00, c0.
  - op=1, count=0, carryIn=1, dataIn=0x33 -> 0x33, c1.
- Backpressure and abort:
  - Hold out_ready=0 for 5 cycles in DONE -> dataOut stable, in_ready=0. Releasing out_ready returns to IDLE with no same-cycle accept.
  - Assert rst_n low during SHIFT with count=7 -> immediate IDLE, all outputs 0.
